// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave = LSU side, master = CPU plus data-memory side.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to report misaligned accesses as errors instead of aligning them down.
module lsu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic        signed_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] cap_q;
    logic [31:0] mem_addr_q;

    logic        accept;
    logic        mis;
    logic [31:0] addr_eff;

    always_comb begin
        accept   = bus.req_valid && (state_q == IDLE);
        addr_eff = bus.req_addr;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
              (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
        mis = 1'b0;
        if (bus.req_size == 2'b01) begin
            addr_eff[0] = 1'b0;
        end else if (bus.req_size[1]) begin
            addr_eff[1:0] = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                err_q    <= mis;
                size_q   <= bus.req_size;
                lane_q   <= addr_eff[1:0];
                wdata_q  <= bus.req_wdata;
                // Misaligned requests never reach memory, so the bus address keeps its old value.
                if (!mis) begin
                    mem_addr_q <= {addr_eff[31:2], 2'b00};
                end
            end
            if (state_q == RD) begin
                cap_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mis) begin
                        state_d = RESP;
                    end else if (!bus.req_we || !bus.req_size[1]) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        merged = cap_q;
        if (size_q == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end

        shifted  = cap_q >> {lane_q, 3'b000};
        load_val = cap_q;
        if (size_q == 2'b00) begin
            load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
        end else if (size_q == 2'b01) begin
            shifted  = lane_q[1] ? {16'h0000, cap_q[31:16]} : {16'h0000, cap_q[15:0]};
            load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.resp_err   = (state_q == RESP) && err_q;
        bus.resp_rdata = '0;
        if ((state_q == RESP) && !we_q && !err_q) begin
            bus.resp_rdata = load_val;
        end
        bus.mem_we    = (state_q == WR);
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = '0;
        if (state_q == WR) begin
            bus.mem_wdata = size_q[1] ? wdata_q : merged;
        end
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  CPU access request.
REQ-005 req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready at a rising edge.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned flag, valid with resp_valid.
REQ-014 mem_we  out  1  word write strobe to data memory (memory writes all 4 bytes at posedge).
REQ-015 mem_addr  out  32  word-aligned address (bits[1:0] = 00).
REQ-016 mem_wdata  out  32  little-endian write word.
REQ-017 mem_rdata  in  32  combinational read data for mem_addr.

Function
REQ-018 States IDLE, RD, WR, RESP; request fields latched on acceptance.
REQ-019 IDLE + accept: misaligned -> RESP (err); load -> RD; word store -> WR; byte/half store -> RD (read-modify-write).
REQ-020 RD: mem_we=0, mem_addr=addr&~3, mem_rdata captured at the clock edge; load -> RESP, sub-word store -> WR.
REQ-021 WR: mem_we=1 for exactly one cycle; word store writes req_wdata; sub-word store writes the captured word with the lane at addr[1:0] (byte) or addr[1] (half) replaced by req_wdata[7:0]/[15:0]; then RESP.
REQ-022 RESP: resp_valid=1 for one cycle, then IDLE; no back-to-back acceptance (req_ready low outside IDLE).
REQ-023 Load extraction: byte lane addr[1:0], half lane addr[1]; sign or zero extend per latched req_signed; word unchanged.
REQ-024 Latency from acceptance edge T: load resp_valid during cycle T+2; word store T+2; sub-word store T+3; misaligned T+1.
REQ-025 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no memory access (mem_we never asserted), resp_rdata=0, resp_err=1.
REQ-026 mem_we SHALL be decoded from state only (glitch-free, never high outside WR).
REQ-027 Outside RD/WR, mem_addr holds last value and mem_wdata=0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, capture register=0.
REQ-029 Reset asserted mid-operation SHALL abort it: no pending write issued, no response produced after release.

Configuration
REQ-030 Macro LSU_MISALIGN_CHECK_EN defined: REQ-025 behaviour applies.
REQ-031 Macro undefined: no error path; address low bits are cleared per size (half: bit0, word: bits[1:0]) and the access proceeds normally; resp_err tied 0.

Verification
REQ-032 Memory word 0x10 = 0x8899AABB; load byte signed @0x13 -> resp_rdata 0xFFFFFF88 at T+2; unsigned -> 0x00000088.
REQ-033 Same word; store half 0x00001234 @0x12 -> single mem_we cycle at T+2, word 0x10 becomes 0x1234AABB, resp_valid at T+3, resp_err=0.
REQ-034 Store word 0xDEADBEEF @0x20 -> mem_we at T+1 with mem_addr 0x20, resp at T+2; subsequent load word @0x20 returns 0xDEADBEEF.
REQ-035 Load word @0x11 with LSU_MISALIGN_CHECK_EN -> resp_valid at T+1, resp_err=1, resp_rdata=0, mem_we never high; without macro -> word from 0x10, resp_err=0.
REQ-036 Store byte @0x10, rst_n pulled low during RD -> mem_we never asserts, word 0x10 unchanged, no resp_valid, req_ready=1 after release.
